ahb_dma: RTL and testbench
==========================

AHB_DMA -- requirements
Module: ahb_dma

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, bus data/address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, transfer-length counter width in words.
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have slave ports: HSELx in 1; HADDR in 32; HWRITE in 1; HSIZE in 3; HBURST in 3 (unused); HTRANS in 2; HMASTLOCK in 1 (unused); HWDATA in 32; HRDATA out 32; HREADY out 1; HRESP out 2.
REQ-005 SHALL have master ports: M_HADDR out 32; M_HWRITE out 1; M_HSIZE out 3; M_HBURST out 3; M_HTRANS out 2; M_HMASTLOCK out 1; M_HWDATA out 32; M_HRDATA in 32; M_HREADY in 1; M_HRESP in 2.
REQ-006 SHALL have ports: dma_int_clear in 1, clears done flag; irq_dma out 1, completion interrupt.

Function
REQ-007 SHALL decode slave offsets HADDR[4:2]: 0 SRC, 1 DST, 2 LEN, 3 CTRL (bit0 start W1, bit1 ie RW), 4 STATUS (bit0 busy, bit1 done, bit2 err; write 1 clears done/err), others read 0, writes ignored.
REQ-008 SHALL latch slave address/write/select in address phase when HSELx & HTRANS[1] & HREADY; write register with HWDATA in following data phase.
REQ-009 SHALL drive HREADY=1 and HRESP=OKAY always; HRDATA valid in data phase, 0 when not selected.
REQ-010 SHALL ignore SRC/DST/LEN/start writes while busy.
REQ-011 SHALL master FSM states: IDLE, RD_A, RD_D, WR_A, WR_D, DONE, ERR.
REQ-012 SHALL on start in IDLE with LEN!=0: load cur_src, cur_dst, remaining=LEN, go RD_A next cycle; LEN==0: go DONE with no bus traffic.
REQ-013 SHALL in RD_A drive M_HTRANS=NONSEQ, M_HWRITE=0, M_HADDR=cur_src; hold until M_HREADY=1, then RD_D.
REQ-014 SHALL in RD_D drive M_HTRANS=IDLE; on M_HREADY=1 capture M_HRDATA into data buffer and go WR_A; M_HRESP=ERROR at M_HREADY=1 goes ERR.
REQ-015 SHALL in WR_A drive NONSEQ, M_HWRITE=1, M_HADDR=cur_dst; on M_HREADY=1 go WR_D.
REQ-016 SHALL in WR_D drive M_HWDATA=buffer, M_HTRANS=IDLE; on M_HREADY=1: src+=4, dst+=4, remaining-=1; remaining reaching 0 goes DONE else RD_A; ERROR response goes ERR.
REQ-017 SHALL hold M_HADDR/M_HWRITE/M_HWDATA stable while M_HREADY=0.
REQ-018 SHALL drive M_HSIZE=word (3'b010), M_HBURST=SINGLE, M_HMASTLOCK=0 constantly.
REQ-019 SHALL wrap address increments modulo 2^32.
REQ-020 SHALL in DONE set done=1, return to IDLE next cycle; ERR sets err=1, returns IDLE next cycle; remaining left as-is.
REQ-021 SHALL assert irq_dma = done & ie, combinationally from registers.
REQ-022 SHALL clear done on dma_int_clear or STATUS write; set-from-DONE wins over simultaneous clear.
REQ-023 SHALL report busy=1 in every state except IDLE.

Reset
REQ-024 SHALL on rst: FSM IDLE; SRC, DST, LEN, ie, done, err, buffer, counters =0; M_HTRANS=IDLE, M_HADDR=0, M_HWDATA=0, M_HWRITE=0; HRDATA=0; irq_dma=0.
REQ-025 SHALL abort mid-transfer on rst, issuing IDLE transfers from next cycle.

Structure
REQ-026 SHALL take HTRANS/HRESP/HSIZE/HBURST encodings and register offsets from the shared defines package.
REQ-027 SHALL keep FSM state encoding local.
REQ-028 SHALL split slave register file into sub-module ahb_dma_regs; master FSM in ahb_dma.

Verification
REQ-029 SRC=0x100, DST=0x200, LEN=3, start, zero-wait memory -> 6 transfers, dst words equal src, done=1 after 12 data/address cycles.
REQ-030 LEN=0, start -> no NONSEQ on master port, done=1 within 2 cycles.
REQ-031 Slave inserts 3 wait states on read -> M_HADDR held 0x100 stable, data captured only at M_HREADY=1.
REQ-032 M_HRESP=ERROR on second write -> err=1, busy=0, remaining=2, no further transfers.
REQ-033 ie=1, completion -> irq_dma=1; dma_int_clear pulse -> irq_dma=0 next cycle.
REQ-034 SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000; rst mid-transfer -> M_HTRANS=IDLE, all registers 0.

Source files
------------

// File: rtl/ahb_dma_pkg.sv
// Shared AHB encodings and register map for the single-channel AHB DMA.
package ahb_dma_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Register offsets, decoded from HADDR[4:2]
    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

endpackage

// File: rtl/ahb_dma_regs.sv
// AHB slave register file for the DMA: SRC/DST/LEN/CTRL/STATUS, start pulse
// generation and the done/err sticky flags.
module ahb_dma_regs
    import ahb_dma_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hsel,
    input  logic [WORD_WIDTH-1:0] i_haddr,
    input  logic                  i_hwrite,
    input  logic [1:0]            i_htrans,
    input  logic [WORD_WIDTH-1:0] i_hwdata,
    output logic [WORD_WIDTH-1:0] o_hrdata,
    input  logic                  i_busy,
    input  logic                  i_set_done,
    input  logic                  i_set_err,
    input  logic                  i_int_clear,
    output logic [WORD_WIDTH-1:0] o_src,
    output logic [WORD_WIDTH-1:0] o_dst,
    output logic [LEN_WIDTH-1:0]  o_len,
    output logic                  o_start,
    output logic                  o_irq
);

    logic                  r_sel;
    logic                  r_write;
    logic [2:0]            r_off;
    logic [WORD_WIDTH-1:0] r_src;
    logic [WORD_WIDTH-1:0] r_dst;
    logic [LEN_WIDTH-1:0]  r_len;
    logic                  r_ie;
    logic                  r_done;
    logic                  r_err;

    logic w_wr;
    logic w_clr_done;
    logic w_clr_err;
    logic w_unused;

    assign w_wr       = r_sel & r_write;
    assign o_start    = w_wr & (r_off == REG_CTRL) & i_hwdata[0] & ~i_busy;
    assign w_clr_done = i_int_clear | (w_wr & (r_off == REG_STATUS) & i_hwdata[1]);
    assign w_clr_err  = w_wr & (r_off == REG_STATUS) & i_hwdata[2];
    assign w_unused   = &{1'b0, i_haddr[WORD_WIDTH-1:5], i_haddr[1:0], i_htrans[0]};

    assign o_src = r_src;
    assign o_dst = r_dst;
    assign o_len = r_len;
    assign o_irq = r_done & r_ie;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= 1'b0;
            r_write <= 1'b0;
            r_off   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_ie    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // HREADY is tied high, so every selected non-idle transfer is accepted
            r_sel   <= i_hsel & i_htrans[1];
            r_write <= i_hwrite;
            r_off   <= i_haddr[4:2];
            if (w_wr && !i_busy) begin
                case (r_off)
                    REG_SRC: r_src <= i_hwdata;
                    REG_DST: r_dst <= i_hwdata;
                    REG_LEN: r_len <= i_hwdata[LEN_WIDTH-1:0];
                    default: ;
                endcase
            end
            if (w_wr && (r_off == REG_CTRL)) r_ie <= i_hwdata[1];
            // A completion in the same cycle as a clear must not be lost
            if (i_set_done)      r_done <= 1'b1;
            else if (w_clr_done) r_done <= 1'b0;
            if (i_set_err)       r_err  <= 1'b1;
            else if (w_clr_err)  r_err  <= 1'b0;
        end
    end

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        o_hrdata = '0;
        if (r_sel && !r_write) begin
            case (r_off)
                REG_SRC:    o_hrdata = r_src;
                REG_DST:    o_hrdata = r_dst;
                REG_LEN:    o_hrdata = WORD_WIDTH'(r_len);
                REG_CTRL:   o_hrdata[1] = r_ie;
                REG_STATUS: o_hrdata[2:0] = {r_err, r_done, i_busy};
                default:    ;
            endcase
        end
    end

endmodule

// File: rtl/ahb_dma.sv
// Single-channel AHB DMA: slave-programmed, copies LEN words src->dst one
// single read/write pair at a time through a one-word buffer.
module ahb_dma
    import ahb_dma_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSELx,
    input  logic [WORD_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic [WORD_WIDTH-1:0] HWDATA,
    output logic [WORD_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic [1:0]            HRESP,
    output logic [WORD_WIDTH-1:0] M_HADDR,
    output logic                  M_HWRITE,
    output logic [2:0]            M_HSIZE,
    output logic [2:0]            M_HBURST,
    output logic [1:0]            M_HTRANS,
    output logic                  M_HMASTLOCK,
    output logic [WORD_WIDTH-1:0] M_HWDATA,
    input  logic [WORD_WIDTH-1:0] M_HRDATA,
    input  logic                  M_HREADY,
    input  logic [1:0]            M_HRESP,
    input  logic                  dma_int_clear,
    output logic                  irq_dma
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_A, S_RD_D, S_WR_A, S_WR_D, S_DONE, S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [WORD_WIDTH-1:0] r_cur_src;
    logic [WORD_WIDTH-1:0] r_cur_dst;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [WORD_WIDTH-1:0] r_buf;

    logic [WORD_WIDTH-1:0] w_src;
    logic [WORD_WIDTH-1:0] w_dst;
    logic [LEN_WIDTH-1:0]  w_len;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_resp_err;
    logic                  w_unused;

    assign w_busy     = (r_state != S_IDLE);
    assign w_resp_err = (M_HRESP == HRESP_ERROR);
    assign w_unused   = &{1'b0, HSIZE, HBURST, HMASTLOCK};

    ahb_dma_regs #(
        .WORD_WIDTH (WORD_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .i_hsel      (HSELx),
        .i_haddr     (HADDR),
        .i_hwrite    (HWRITE),
        .i_htrans    (HTRANS),
        .i_hwdata    (HWDATA),
        .o_hrdata    (HRDATA),
        .i_busy      (w_busy),
        .i_set_done  (r_state == S_DONE),
        .i_set_err   (r_state == S_ERR),
        .i_int_clear (dma_int_clear),
        .o_src       (w_src),
        .o_dst       (w_dst),
        .o_len       (w_len),
        .o_start     (w_start),
        .o_irq       (irq_dma)
    );

    assign HREADY = 1'b1;
    assign HRESP  = HRESP_OKAY;

    // Outputs derive from registers that only move on M_HREADY, so they hold during waits
    assign M_HTRANS    = (r_state == S_RD_A || r_state == S_WR_A) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign M_HWRITE    = (r_state == S_WR_A || r_state == S_WR_D);
    assign M_HADDR     = M_HWRITE ? r_cur_dst : r_cur_src;
    assign M_HWDATA    = r_buf;
    assign M_HSIZE     = HSIZE_WORD;
    assign M_HBURST    = HBURST_SINGLE;
    assign M_HMASTLOCK = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_buf       <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_cur_src   <= w_src;
                    r_cur_dst   <= w_dst;
                    r_remaining <= w_len;
                end
                S_RD_D: if (M_HREADY && !w_resp_err) r_buf <= M_HRDATA;
                S_WR_D: if (M_HREADY && !w_resp_err) begin
                    r_cur_src   <= r_cur_src + WORD_WIDTH'(4);
                    r_cur_dst   <= r_cur_dst + WORD_WIDTH'(4);
                    r_remaining <= r_remaining - LEN_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_next = (w_len == '0) ? S_DONE : S_RD_A;
            S_RD_A: if (M_HREADY) w_next = S_RD_D;
            S_RD_D: if (M_HREADY) w_next = w_resp_err ? S_ERR : S_WR_A;
            S_WR_A: if (M_HREADY) w_next = S_WR_D;
            S_WR_D: if (M_HREADY) begin
                if (w_resp_err)                            w_next = S_ERR;
                else if (r_remaining == LEN_WIDTH'(1))     w_next = S_DONE;
                else                                       w_next = S_RD_A;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb_dma.sv
// Self-checking bench for ahb_dma: AHB memory model on the master port,
// register reads and DMA writes checked against bench-computed expectations.
module tb_ahb_dma;
    import ahb_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        HSELx = 1'b0;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = HSIZE_WORD;
    logic [2:0]  HBURST = HBURST_SINGLE;
    logic [1:0]  HTRANS = HTRANS_IDLE;
    logic        HMASTLOCK = 1'b0;
    logic [31:0] HWDATA = '0;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] M_HADDR;
    logic        M_HWRITE;
    logic [2:0]  M_HSIZE;
    logic [2:0]  M_HBURST;
    logic [1:0]  M_HTRANS;
    logic        M_HMASTLOCK;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA = '0;
    logic        M_HREADY = 1'b1;
    logic [1:0]  M_HRESP = HRESP_OKAY;
    logic        dma_int_clear = 1'b0;
    logic        irq_dma;

    always #5 clk = ~clk;

    ahb_dma dut (
        .clk(clk), .rst(rst),
        .HSELx(HSELx), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP),
        .M_HADDR(M_HADDR), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE), .M_HBURST(M_HBURST),
        .M_HTRANS(M_HTRANS), .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA),
        .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
        .dma_int_clear(dma_int_clear), .irq_dma(irq_dma)
    );

    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [2:0] off; logic [31:0] val; } rd_t;

    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [31:0] rd_addrs[$];
    logic [31:0] mem [logic [31:0]];

    int   n_checks = 0;
    int   n_errors = 0;
    int   wait_mode = 0;     // 0: zero-wait, 1: three waits, 2: random 0..3
    int   err_on_wr = 0;     // 1-based write index answered with ERROR, 0 = none
    int   wr_count = 0;
    int   nonseq_count = 0;
    logic s_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Master-port memory model; also the scoreboard monitor for DMA writes
    initial begin : mem_model
        logic        dp_active;
        logic        dp_write;
        logic [31:0] dp_addr;
        int          wait_left;
        logic        p_rdy, p_rst, p_write;
        logic [1:0]  p_trans, p_resp;
        logic [31:0] p_addr, p_wdata;
        wr_t         e;
        dp_active = 1'b0; dp_write = 1'b0; dp_addr = '0; wait_left = 0;
        p_rdy = 1'b1; p_rst = 1'b1; p_write = 1'b0; p_trans = HTRANS_IDLE;
        p_resp = HRESP_OKAY; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            if (p_rst || rst) begin
                dp_active = 1'b0;
            end else if (p_rdy) begin
                if (dp_active && dp_write) begin
                    wr_count++;
                    if (p_resp == HRESP_OKAY) begin
                        mem[dp_addr] = p_wdata;
                        if (exp_wr.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL dma_wr_extra: got write 0x%08h to 0x%08h expected none", p_wdata, dp_addr);
                        end else begin
                            e = exp_wr.pop_front();
                            check("dma_wr_addr", dp_addr, e.addr);
                            check("dma_wr_data", p_wdata, e.data);
                        end
                    end
                end
                if (p_trans == HTRANS_NONSEQ) begin
                    dp_active = 1'b1;
                    dp_addr   = p_addr;
                    dp_write  = p_write;
                    wait_left = (wait_mode == 1) ? 3 : (wait_mode == 2) ? int'($urandom_range(3, 0)) : 0;
                    nonseq_count++;
                    if (!p_write) rd_addrs.push_back(p_addr);
                end else begin
                    dp_active = 1'b0;
                end
            end else begin
                check("hold_haddr", M_HADDR, p_addr);
                check("hold_hwrite", 32'(M_HWRITE), 32'(p_write));
                check("hold_hwdata", M_HWDATA, p_wdata);
                wait_left--;
            end
            M_HREADY = !(dp_active && wait_left > 0);
            M_HRDATA = (dp_active && !dp_write && M_HREADY) ? mem_rd(dp_addr) : 32'hDEAD_BEEF;
            M_HRESP  = (dp_active && dp_write && M_HREADY && (wr_count + 1 == err_on_wr))
                       ? HRESP_ERROR : HRESP_OKAY;
            p_rdy = M_HREADY; p_rst = rst; p_trans = M_HTRANS; p_addr = M_HADDR;
            p_write = M_HWRITE; p_wdata = M_HWDATA; p_resp = M_HRESP;
        end
    end

    // Slave read monitor: checks HRDATA during the data phase of tagged reads
    initial begin : rd_monitor
        rd_t e;
        forever begin
            @(posedge clk);
            #2;
            if (s_chk && HSELx && HTRANS[1] && !HWRITE && exp_rd.size() != 0) begin
                e = exp_rd.pop_front();
                check($sformatf("reg_rd_off%0d", e.off), HRDATA, e.val);
            end
        end
    end

    task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = {27'b0, off, 2'b00};
        @(negedge clk);
        HSELx = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HWDATA = data;
        @(negedge clk);
    endtask

    task automatic bus_read_raw(input logic [2:0] off, output logic [31:0] data);
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {27'b0, off, 2'b00};
        @(negedge clk);
        HSELx = 1'b0; HTRANS = HTRANS_IDLE;
        data = HRDATA;
    endtask

    task automatic bus_read_chk(input logic [2:0] off, input logic [31:0] val);
        exp_rd.push_back('{off: off, val: val});
        s_chk = 1'b1;
        HSELx = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0; HADDR = {27'b0, off, 2'b00};
        @(negedge clk);
        s_chk = 1'b0;
        HSELx = 1'b0; HTRANS = HTRANS_IDLE;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] st;
        int i;
        for (i = 0; i < budget; i++) begin
            bus_read_raw(REG_STATUS, st);
            if (!st[0]) break;
        end
        check("wait_idle_in_budget", 32'(i < budget), 32'd1);
    endtask

    task automatic run_job(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input logic ie, input int err_wr, input int mode, input logic poke);
        int   xfers;
        int   cyc;
        logic err_exp;
        wait_mode = mode; err_on_wr = err_wr; wr_count = 0; nonseq_count = 0;
        rd_addrs.delete();
        err_exp = (err_wr != 0) && (err_wr <= len);
        for (int i = 0; i < len; i++) mem[src + 32'(4 * i)] = $urandom;
        for (int i = 0; i < len; i++) begin
            if (err_exp && i + 1 == err_wr) break;
            exp_wr.push_back('{addr: dst + 32'(4 * i), data: mem[src + 32'(4 * i)]});
        end
        xfers = err_exp ? 2 * err_wr : 2 * len;
        bus_write(REG_SRC, src);
        bus_write(REG_DST, dst);
        bus_write(REG_LEN, 32'(len));
        bus_write(REG_CTRL, {30'b0, ie, 1'b1});
        if (poke) begin
            bus_write(REG_SRC, 32'hBAD0_0000);
            bus_write(REG_LEN, 32'd7);
            bus_write(REG_CTRL, {30'b0, ie, 1'b1});
        end
        if (ie && !err_exp) begin
            cyc = 0;
            while (!irq_dma && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            check("irq_in_budget", 32'(cyc < 500), 32'd1);
            if (mode == 0 && !poke) check("done_latency", 32'(cyc), 32'(4 * len + 1));
        end else begin
            wait_idle(300);
        end
        repeat (2) @(negedge clk);
        check("xfer_count", 32'(nonseq_count), 32'(xfers));
        check("wr_pending", 32'(exp_wr.size()), 32'd0);
        exp_wr.delete();
        if (len > 0) check("first_rd_addr", (rd_addrs.size() > 0) ? rd_addrs[0] : ~src, src);
        bus_read_chk(REG_STATUS, err_exp ? 32'h4 : 32'h2);
        bus_read_chk(REG_CTRL, {30'b0, ie, 1'b0});
        if (poke) begin
            bus_read_chk(REG_SRC, src);
            bus_read_chk(REG_LEN, 32'(len));
        end
        check("irq", 32'(irq_dma), 32'(ie && !err_exp));
        if (ie && !err_exp) begin
            dma_int_clear = 1'b1;
            @(negedge clk);
            dma_int_clear = 1'b0;
            check("irq_after_clear", 32'(irq_dma), 32'd0);
        end
        bus_write(REG_STATUS, 32'h6);
        bus_read_chk(REG_STATUS, 32'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : stim
        int len;
        int err;
        repeat (3) @(negedge clk);
        check("rst_htrans", 32'(M_HTRANS), 32'(HTRANS_IDLE));
        check("rst_haddr", M_HADDR, 32'h0);
        check("rst_hwdata", M_HWDATA, 32'h0);
        check("rst_hwrite", 32'(M_HWRITE), 32'd0);
        check("rst_irq", 32'(irq_dma), 32'd0);
        check("hready_hresp", {29'b0, HREADY, HRESP}, 32'h4);
        rst = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 5; r++) bus_read_chk(3'(r), 32'h0);

        run_job(32'h0000_0100, 32'h0000_0200, 3, 1'b1, 0, 0, 1'b0);
        run_job(32'h0000_0100, 32'h0000_0200, 0, 1'b1, 0, 0, 1'b0);
        check("len0_no_traffic", 32'(nonseq_count), 32'd0);
        run_job(32'h0000_0100, 32'h0000_0300, 2, 1'b0, 0, 1, 1'b0);
        run_job(32'h0000_0100, 32'h0000_0400, 3, 1'b1, 2, 0, 1'b0);
        run_job(32'hFFFF_FFFC, 32'h0000_0500, 2, 1'b0, 0, 0, 1'b0);
        check("wrap_rd_addr", (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hFFFF_FFFF, 32'h0);
        run_job(32'h0000_1000, 32'h0000_2000, 4, 1'b1, 0, 2, 1'b1);

        for (int j = 0; j < 6; j++) begin
            len = int'($urandom_range(6, 1));
            err = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 1)) : 0;
            run_job(32'h1000_0000 | ($urandom & 32'h00FF_FFFC),
                    32'h2000_0000 | ($urandom & 32'h00FF_FFFC),
                    len, 1'($urandom_range(1, 0)), err, int'($urandom_range(2, 0)), 1'b0);
        end

        // Reset in the middle of a transfer
        wait_mode = 0; err_on_wr = 0;
        for (int i = 0; i < 5; i++) mem[32'h0000_0100 + 32'(4 * i)] = $urandom;
        for (int i = 0; i < 5; i++)
            exp_wr.push_back('{addr: 32'h0000_0600 + 32'(4 * i), data: mem[32'h0000_0100 + 32'(4 * i)]});
        bus_write(REG_SRC, 32'h0000_0100);
        bus_write(REG_DST, 32'h0000_0600);
        bus_write(REG_LEN, 32'd5);
        bus_write(REG_CTRL, 32'h3);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_htrans", 32'(M_HTRANS), 32'(HTRANS_IDLE));
        check("abort_haddr", M_HADDR, 32'h0);
        check("abort_hwdata", M_HWDATA, 32'h0);
        check("abort_hwrite", 32'(M_HWRITE), 32'd0);
        check("abort_irq", 32'(irq_dma), 32'd0);
        check("abort_hrdata", HRDATA, 32'h0);
        rst = 1'b0;
        exp_wr.delete();
        @(negedge clk);
        for (int r = 0; r < 5; r++) bus_read_chk(3'(r), 32'h0);
        repeat (3) @(negedge clk);
        check("abort_quiet", 32'(M_HTRANS), 32'(HTRANS_IDLE));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
